// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and initiator side of the sequential divider handshake.
// Decodes DIVU/MTHI/MTLO/MFHI/MFLO in EX and stalls HI/LO accesses while a divide is in flight.
module hilo_div_ctrl #(
  parameter int TIMEOUT  = 40,
  parameter int MIN_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        dz,
  output logic        timeout_err,
  output logic        div_reset,
  output logic        div_signal,
  output logic [31:0] div_dataA,
  output logic [31:0] div_dataB,
  input  logic        div_stop,
  input  logic [63:0] div_dataOut
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;
  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MFLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   div_data_a_q, div_data_a_d;
  logic [31:0]   div_data_b_q, div_data_b_d;
  logic          div_signal_q, div_signal_d;
  logic          dz_q, dz_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic op_active;

  assign op_active = (op == OP_DIVU) || (op == OP_MTHI) || (op == OP_MTLO) ||
                     (op == OP_MFHI) || (op == OP_MFLO);

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    div_data_a_d  = div_data_a_q;
    div_data_b_d  = div_data_b_q;
    div_signal_d  = div_signal_q;
    dz_d          = dz_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        case (op)
          OP_DIVU: begin
            dz_d          = 1'b0;
            timeout_err_d = 1'b0;
            if (rt_data == 32'd0) begin
              // Divide by zero never reaches the divider; result is fixed.
              hi_d = rs_data;
              lo_d = 32'hFFFF_FFFF;
              dz_d = 1'b1;
            end else begin
              div_data_a_d = rs_data;
              div_data_b_d = rt_data;
              div_signal_d = 1'b1;
              cnt_d        = '0;
              state_d      = S_BUSY;
            end
          end
          OP_MTHI: hi_d = rs_data;
          OP_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
      S_BUSY: begin
        // Early stop is stale from the previous divide and must be ignored.
        if ((cnt_q >= CW'(MIN_WAIT)) && div_stop) begin
          hi_d         = div_dataOut[63:32];
          lo_d         = div_dataOut[31:0];
          div_signal_d = 1'b0;
          state_d      = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          div_signal_d  = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      div_data_a_q  <= '0;
      div_data_b_q  <= '0;
      div_signal_q  <= 1'b0;
      dz_q          <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      div_data_a_q  <= div_data_a_d;
      div_data_b_q  <= div_data_b_d;
      div_signal_q  <= div_signal_d;
      dz_q          <= dz_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI) rd_data = hi_q;
    else if (op == OP_MFLO) rd_data = lo_q;
  end

  assign busy        = (state_q != S_IDLE);
  assign stall       = busy && op_active;
  assign div_reset   = reset || (state_q == S_ABORT);
  assign div_signal  = div_signal_q;
  assign div_dataA   = div_data_a_q;
  assign div_dataB   = div_data_b_q;
  assign dz          = dz_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: behavioural divider with programmable latency, a transaction-level
// HI/LO reference model, a vector table, hand sequences for the multi-cycle corners, and random ops.
module tb_hilo_div_ctrl;

  localparam int TIMEOUT  = 40;
  localparam int MIN_WAIT = 2;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] DIVU = 3'd1;
  localparam logic [2:0] MTHI = 3'd2;
  localparam logic [2:0] MTLO = 3'd3;
  localparam logic [2:0] MFHI = 3'd4;
  localparam logic [2:0] MFLO = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, rd_data;
  logic        stall, busy, dz, timeout_err, div_reset, div_signal, div_stop;
  logic [31:0] div_dataA, div_dataB;
  logic [63:0] div_dataOut;

  always #5 clk = ~clk;

  hilo_div_ctrl #(.TIMEOUT(TIMEOUT), .MIN_WAIT(MIN_WAIT)) dut (
    .clk(clk), .reset(reset), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .rd_data(rd_data), .stall(stall), .busy(busy), .dz(dz), .timeout_err(timeout_err),
    .div_reset(div_reset), .div_signal(div_signal), .div_dataA(div_dataA),
    .div_dataB(div_dataB), .div_stop(div_stop), .div_dataOut(div_dataOut)
  );

  // Behavioural divider: stop rises after dlat+1 cycles of div_signal; latency captured while idle.
  int lat = 0;
  int dlat = 0;
  int dcnt = 0;
  always @(posedge clk) begin
    if (!div_signal) dlat <= lat;
    if (div_reset || !div_signal) begin
      dcnt     <= 0;
      div_stop <= 1'b0;
    end else if (dcnt >= dlat) div_stop <= 1'b1;
    else dcnt <= dcnt + 1;
  end
  assign div_dataOut = (div_dataB != 0) ? {div_dataA % div_dataB, div_dataA / div_dataB} : 64'd0;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining busy cycles and the outcome of the divide in flight.
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0, p_hi = 0, p_lo = 0;
  logic        m_dz = 0, m_te = 0, m_abort = 0;
  int          m_left = 0;

  int          n_busy, n_rst, n_stall;
  logic [31:0] last_rd;
  logic        last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_active(input logic [2:0] o);
    return (o >= DIVU) && (o <= MFLO);
  endfunction

  task automatic check_cycle();
    logic        e_busy, e_last;
    logic [31:0] e_rd;
    e_busy = (m_left > 0);
    e_last = m_abort && (m_left == 1);
    e_rd   = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
    chk("busy", busy, e_busy);
    chk("stall", stall, e_busy && is_active(op));
    chk("div_signal", div_signal, e_busy && !e_last);
    chk("div_reset", div_reset, reset || e_last);
    chk("rd_data", rd_data, e_rd);
    chk("dz", dz, m_dz);
    if (!e_busy) chk("timeout_err", timeout_err, m_te);
    if (e_busy && !e_last) begin
      chk("div_dataA", div_dataA, m_a);
      chk("div_dataB", div_dataB, m_b);
    end
    if (busy) n_busy++;
    if (div_reset) n_rst++;
    if (stall) n_stall++;
    last_rd  = rd_data;
    last_acc = !e_busy && !reset;
  endtask

  task automatic model_update();
    int k;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_dz = 0; m_te = 0; m_abort = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_abort) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else begin
      case (op)
        DIVU: begin
          m_dz = 0;
          m_te = 0;
          if (rt_data == 0) begin
            m_hi = rs_data; m_lo = 32'hFFFF_FFFF; m_dz = 1;
          end else begin
            m_a = rs_data;
            m_b = rt_data;
            k = (lat + 1 > MIN_WAIT) ? lat + 1 : MIN_WAIT;
            if (k <= TIMEOUT - 1) begin
              m_left = k + 1; m_abort = 0;
              p_hi = rs_data % rt_data; p_lo = rs_data / rt_data;
            end else begin
              m_left = TIMEOUT + 1; m_abort = 1; m_te = 1;
            end
          end
        end
        MTHI: m_hi = rs_data;
        MTLO: m_lo = rs_data;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int l);
    op = o; rs_data = a; rt_data = b; lat = l;
    for (int n = 0; n < 100; n++) begin
      cycle();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      failures++;
      $display("FAIL accept_wait actual=not_accepted required=accepted t=%0t", $time);
    end
    op = NOP;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && m_left > 0; n++) cycle();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          lat;
    logic [31:0] hi, lo;
    logic        dz, te;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{DIVU, 32'd100,        32'd7,  32, 32'd2,        32'd14,        1'b0, 1'b0};
    vecs[1] = '{DIVU, 32'd5,          32'd0,  0,  32'd5,        32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{MTHI, 32'hDEAD_BEEF,  32'd0,  0,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{MTLO, 32'h1234_5678,  32'd0,  0,  32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0};
    vecs[4] = '{DIVU, 32'hFFFF_FFFF,  32'h10, 5,  32'hF,        32'h0FFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{DIVU, 32'd9,          32'd3,  0,  32'd0,        32'd3,         1'b0, 1'b0};
    vecs[6] = '{DIVU, 32'd1000,       32'd3,  38, 32'd1,        32'd333,       1'b0, 1'b0};
    vecs[7] = '{DIVU, 32'd50,         32'd7,  39, 32'd1,        32'd333,       1'b0, 1'b1};
    vecs[8] = '{DIVU, 32'd7,          32'd0,  0,  32'd7,        32'hFFFF_FFFF, 1'b1, 1'b0};

    reset = 1'b1; op = NOP; rs_data = 0; rt_data = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_hi", dut.rd_data, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      n_busy = 0;
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].lat);
      wait_idle();
      if (i == 0) chk("busy_cycles_100_7", n_busy, 34);
      if (i == 5) chk("busy_cycles_min_wait", n_busy, MIN_WAIT + 1);
      if (i == 6) chk("busy_cycles_edge", n_busy, TIMEOUT);
      chk("vec_dz", dz, vecs[i].dz);
      chk("vec_te", timeout_err, vecs[i].te);
      issue(MFHI, 0, 0, 0);
      chk("vec_hi", last_rd, vecs[i].hi);
      issue(MFLO, 0, 0, 0);
      chk("vec_lo", last_rd, vecs[i].lo);
    end

    // MFLO held from the fourth BUSY cycle until the divide completes.
    issue(DIVU, 32'hFFFF_FFFF, 32'h10, 20);
    repeat (3) cycle();
    n_stall = 0;
    issue(MFLO, 0, 0, 0);
    chk("held_mflo", last_rd, 32'h0FFF_FFFF);
    chk("held_stall_cycles", n_stall, 19);
    issue(MFHI, 0, 0, 0);
    chk("held_mfhi", last_rd, 32'hF);

    // Reset in the middle of a divide.
    issue(DIVU, 32'd1234, 32'd11, 30);
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_divsig", div_signal, 1'b0);
    issue(MFHI, 0, 0, 0);
    chk("rst_mfhi", last_rd, 32'd0);
    issue(MFLO, 0, 0, 0);
    chk("rst_mflo", last_rd, 32'd0);
    issue(DIVU, 32'd9, 32'd3, 3);
    wait_idle();
    issue(MFLO, 0, 0, 0);
    chk("post_rst_lo", last_rd, 32'd3);
    issue(MFHI, 0, 0, 0);
    chk("post_rst_hi", last_rd, 32'd0);

    // Divider that never finishes.
    n_busy = 0; n_rst = 0;
    issue(DIVU, 32'd77, 32'd5, 1000);
    wait_idle();
    chk("to_busy_cycles", n_busy, TIMEOUT + 1);
    chk("to_div_reset_pulses", n_rst, 1);
    chk("to_err", timeout_err, 1'b1);
    issue(MFLO, 0, 0, 0);
    chk("to_lo_kept", last_rd, 32'd3);

    // Random op stream with held ops, zero divisors and latencies either side of the timeout.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(3'($urandom_range(0, 7)), $urandom, b, $urandom_range(0, 45));
      if ($urandom_range(0, 3) == 0) cycle();
    end
    wait_idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
